// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered load results into a
// single registered register-file write per cycle, with write-after-write ordering.
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_alu_valid,
    input  logic [4:0]               i_alu_rd,
    input  logic [XLEN-1:0]          i_alu_data,
    output logic                     o_alu_ready,
    input  logic                     i_ld_valid,
    input  logic [4:0]               i_ld_rd,
    input  logic [XLEN-1:0]          i_ld_data,
    output logic                     o_ld_ready,
    output logic                     o_wen,
    output logic [4:0]               o_waddr,
    output logic [XLEN-1:0]          o_wdata,
    output logic [31:0]              o_ld_pending,
    output logic [$clog2(DEPTH):0]   o_fifo_cnt
);

    // Handshake: a producer's result transfers on a rising edge where valid and
    // ready are both high; the producer holds valid/rd/data stable until then.

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            full;
    logic            alu_waw;
    logic            alu_fire;
    logic            push;
    logic            pop;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     pend;

    assign full = (count == CW'(DEPTH));

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(PW'(PW'(i) - rd_ptr)) < count) begin
                pend[q_rd[i]] = 1'b1;
            end
        end
        pend[0] = 1'b0;
    end

    assign alu_waw     = (i_alu_rd != 5'd0) && pend[i_alu_rd];
    assign o_alu_ready = !full && !alu_waw;
    assign o_ld_ready  = !full;

    // A full FIFO already blocks the ALU, so the ALU wins only when not full.
    assign alu_fire  = i_alu_valid && o_alu_ready;
    assign pop       = !alu_fire && (count != '0);
    assign push      = i_ld_valid && o_ld_ready && (i_ld_rd != 5'd0);
    assign sel_valid = alu_fire || pop;
    assign sel_rd    = alu_fire ? i_alu_rd   : q_rd[rd_ptr];
    assign sel_data  = alu_fire ? i_alu_data : q_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= i_ld_rd;
            q_data[wr_ptr] <= i_ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            o_wen   <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            o_wen <= sel_valid && (sel_rd != 5'd0);
            // Address/data only move on a real write so they never glitch idle.
            if (sel_valid && (sel_rd != 5'd0)) begin
                o_waddr <= sel_rd;
                o_wdata <= sel_data;
            end
        end
    end

    assign o_ld_pending = pend;
    assign o_fifo_cnt   = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued at stimulus time
// and a negedge monitor pops and compares every register-file write.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int XLEN  = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst;
  logic            i_alu_valid;
  logic [4:0]      i_alu_rd;
  logic [XLEN-1:0] i_alu_data;
  logic            o_alu_ready;
  logic            i_ld_valid;
  logic [4:0]      i_ld_rd;
  logic [XLEN-1:0] i_ld_data;
  logic            o_ld_ready;
  logic            o_wen;
  logic [4:0]      o_waddr;
  logic [XLEN-1:0] o_wdata;
  logic [31:0]     o_ld_pending;
  logic [CW-1:0]   o_fifo_cnt;

  int total = 0;
  int bad = 0;
  logic [5+XLEN-1:0] exp_q[$];
  logic [5+XLEN-1:0] mon_e;

  wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_alu_valid  (i_alu_valid),
    .i_alu_rd     (i_alu_rd),
    .i_alu_data   (i_alu_data),
    .o_alu_ready  (o_alu_ready),
    .i_ld_valid   (i_ld_valid),
    .i_ld_rd      (i_ld_rd),
    .i_ld_data    (i_ld_data),
    .o_ld_ready   (o_ld_ready),
    .o_wen        (o_wen),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_ld_pending (o_ld_pending),
    .o_fifo_cnt   (o_fifo_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    i_alu_valid = v;
    i_alu_rd    = rd;
    i_alu_data  = d;
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    i_ld_valid = v;
    i_ld_rd    = rd;
    i_ld_data  = d;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [XLEN-1:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && o_wen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", o_waddr, o_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_waddr, o_wdata} !== mon_e) begin
          bad++;
          $display("FAIL write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                   o_waddr, o_wdata, mon_e[5+XLEN-1:XLEN], mon_e[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive_alu(1'b0, 5'd0, '0);
    drive_ld(1'b0, 5'd0, '0);
    #12;
    check("rst_wen", o_wen, 0);
    check("rst_cnt", o_fifo_cnt, 0);
    check("rst_pending", o_ld_pending, 0);
    check("rst_ld_ready", o_ld_ready, 1);
    check("rst_alu_ready", o_alu_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // ALU only
    drive_alu(1'b1, 5'd5, 64'h1234);
    expect_wr(5'd5, 64'h1234);
    #1;
    check("t1_alu_ready", o_alu_ready, 1);
    step();
    drive_alu(1'b0, 5'd0, '0);
    #1;
    check("t1_alu_ready_after", o_alu_ready, 1);
    step();

    // load then idle
    drive_ld(1'b1, 5'd7, 64'hAA);
    expect_wr(5'd7, 64'hAA);
    #1;
    check("t2_ld_ready", o_ld_ready, 1);
    step();
    drive_ld(1'b0, 5'd0, '0);
    #1;
    check("t2_cnt1", o_fifo_cnt, 1);
    check("t2_pending7", o_ld_pending, 32'h80);
    step();
    check("t2_cnt0", o_fifo_cnt, 0);
    check("t2_pending_clr", o_ld_pending, 0);

    // full FIFO priority: A1, A2, L3, A3, L4
    drive_alu(1'b1, 5'd9, 64'h901);
    drive_ld(1'b1, 5'd3, 64'h33);
    expect_wr(5'd9, 64'h901);
    expect_wr(5'd9, 64'h902);
    expect_wr(5'd3, 64'h33);
    expect_wr(5'd9, 64'h903);
    expect_wr(5'd4, 64'h44);
    #1;
    check("t3_c0_alu_ready", o_alu_ready, 1);
    check("t3_c0_ld_ready", o_ld_ready, 1);
    step();
    drive_alu(1'b1, 5'd9, 64'h902);
    drive_ld(1'b1, 5'd4, 64'h44);
    #1;
    check("t3_c1_cnt", o_fifo_cnt, 1);
    check("t3_c1_alu_ready", o_alu_ready, 1);
    step();
    drive_alu(1'b1, 5'd9, 64'h903);
    drive_ld(1'b0, 5'd0, '0);
    #1;
    check("t3_full_cnt", o_fifo_cnt, 2);
    check("t3_full_ld_ready", o_ld_ready, 0);
    check("t3_full_alu_ready", o_alu_ready, 0);
    check("t3_full_pending", o_ld_pending, 32'h18);
    step();
    check("t3_c3_cnt", o_fifo_cnt, 1);
    check("t3_c3_alu_ready", o_alu_ready, 1);
    check("t3_c3_pending", o_ld_pending, 32'h10);
    step();
    drive_alu(1'b0, 5'd0, '0);
    #1;
    check("t3_c4_cnt", o_fifo_cnt, 1);
    step();
    check("t3_c5_cnt", o_fifo_cnt, 0);

    // WAW guard: load x6 then ALU x6
    drive_ld(1'b1, 5'd6, 64'h66);
    expect_wr(5'd6, 64'h66);
    expect_wr(5'd6, 64'h600);
    step();
    drive_ld(1'b0, 5'd0, '0);
    drive_alu(1'b1, 5'd6, 64'h600);
    #1;
    check("t4_waw_block", o_alu_ready, 0);
    check("t4_pending6", o_ld_pending, 32'h40);
    step();
    check("t4_waw_release", o_alu_ready, 1);
    check("t4_cnt", o_fifo_cnt, 0);
    step();
    drive_alu(1'b0, 5'd0, '0);
    step();

    // x0 handling
    drive_alu(1'b1, 5'd0, 64'hDEAD);
    drive_ld(1'b1, 5'd0, 64'hBEEF);
    #1;
    check("t5_alu_ready", o_alu_ready, 1);
    check("t5_ld_ready", o_ld_ready, 1);
    step();
    drive_alu(1'b0, 5'd0, '0);
    drive_ld(1'b0, 5'd0, '0);
    #1;
    check("t5_cnt", o_fifo_cnt, 0);
    check("t5_pending", o_ld_pending, 0);
    step();
    check("t5_wen", o_wen, 0);
    check("t5_waddr_hold", o_waddr, 6);
    check("t5_wdata_hold", o_wdata, 64'h600);

    // async reset with two loads queued
    drive_alu(1'b1, 5'd10, 64'hA0);
    drive_ld(1'b1, 5'd11, 64'hB1);
    expect_wr(5'd10, 64'hA0);
    step();
    drive_alu(1'b1, 5'd12, 64'hA1);
    drive_ld(1'b1, 5'd13, 64'hB2);
    step();
    drive_alu(1'b0, 5'd0, '0);
    drive_ld(1'b0, 5'd0, '0);
    #1;
    check("t6_pre_cnt", o_fifo_cnt, 2);
    rst = 1'b1;
    #1;
    check("t6_rst_wen", o_wen, 0);
    check("t6_rst_cnt", o_fifo_cnt, 0);
    check("t6_rst_pending", o_ld_pending, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (4) step();
    check("t6_post_wen", o_wen, 0);
    check("t6_post_cnt", o_fifo_cnt, 0);

    // final report
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_exp_q", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file write port.
- Merges single-cycle ALU results and out-of-order-latency load results into one registered write (wen/addr/wdata) per cycle.
- Load results are buffered in a small FIFO.
- Write-after-write ordering is enforced, and a pending-load bitmap is exported for decode hazard stalls.

Parameters:
- DEPTH, 2: load-result FIFO entries; power of two, ≥2.
- XLEN, 64: data width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- i_alu_valid  in  1  ALU result present
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  XLEN  ALU result
- o_alu_ready  out  1  ALU result accepted this cycle (combinational)
- i_ld_valid  in  1  load result present
- i_ld_rd  in  5  load destination register
- i_ld_data  in  XLEN  load data
- o_ld_ready  out  1  load result accepted this cycle (combinational)
- o_wen  out  1  register-file write enable (registered)
- o_waddr  out  5  register-file write address (registered)
- o_wdata  out  XLEN  register-file write data (registered)
- o_ld_pending  out  32  bit r set while a load to xr sits in the FIFO; bit 0 always 0
- o_fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: asynchronous, active-high. Flushes the FIFO (count, rd/wr pointers = 0). Clears o_wen, o_waddr, o_wdata and o_ld_pending to 0. Reset mid-operation discards all queued loads. No write is issued in the cycle following reset release unless an input is valid.
- Handshakes:
  - A transfer occurs when valid & ready are both high at a rising edge.
  - Producers hold valid/rd/data stable until accepted.
- Ready rules, evaluated from current state only:
  - o_ld_ready = (count < DEPTH). Simultaneous drain does not raise it.
  - o_alu_ready = !(count == DEPTH) & !o_ld_pending[i_alu_rd]. That is: a full FIFO forces a drain, and the WAW guard prevents a younger ALU write from being overwritten by an older queued load.
  - i_alu_rd == 0 bypasses the WAW term.
- Write selection per cycle, priority order:
  1. count == DEPTH → drain FIFO head.
  2. i_alu_valid & o_alu_ready → ALU result.
  3. count > 0 → drain FIFO head.
  4. Otherwise no write.
- The selected result is registered: o_wen/o_waddr/o_wdata are valid on the cycle after selection (latency 1 from ALU accept; ≥1 from FIFO head).
- o_wen is forced to 0 when the selected rd == 0. The slot is still consumed.
- FIFO:
  - A load with rd == 0 is accepted (when ready) but not enqueued.
  - Push and pop in the same cycle leave count unchanged. The push writes at wr_ptr, the pop advances rd_ptr.
  - Pointers wrap modulo DEPTH.
  - An entry is retired in the cycle it is selected.
- o_ld_pending is combinational: OR of one-hot(rd) over valid FIFO entries.
  - It excludes the output register. The register file forwards its write port, so no stall is needed for that stage.
- Ordering: loads retire in acceptance order. An ALU write is never issued while a same-rd load is queued.
- No X propagation: o_waddr/o_wdata hold their last values when o_wen = 0.

Test Plan:
- ALU only: alu_valid, rd=5, data=0x1234 → next cycle o_wen=1, o_waddr=5, o_wdata=0x1234; o_alu_ready=1 throughout.
- Load then idle: ld rd=7, data=0xAA accepted → o_ld_pending[7]=1 and o_fifo_cnt=1 for one cycle → o_wen=1, addr 7, data 0xAA the following cycle, pending cleared.
- Full-FIFO priority: fill 2 loads (rd 3, 4) while ALU continuously valid with rd=9:
  - o_ld_ready=0 at count=2.
  - o_alu_ready=0, rd 3 written first.
  - ALU rd 9 is then written before rd 4 drains.
- WAW guard: queue load rd=6, then present ALU rd=6 → o_alu_ready=0 until the load drains. Writes occur in order: load data, then ALU data to x6.
- x0 handling: ALU rd=0 and load rd=0 → both accepted, o_wen stays 0, count stays 0, o_ld_pending[0]=0.
- Async reset mid-operation: assert rst with 2 entries queued → o_wen=0, o_fifo_cnt=0, o_ld_pending=0 immediately, with no pending write after release.
